pwrgood_monitor: RTL

Conditions the four raw user-area power-good flags before they reach the system-control register block. Each flag is synchronized into the management clock domain and debounced with a programmable hold-off. Rise and fall events are latched in sticky flags with a maskable interrupt. The clean flags drive `usr1_vcc_pwrgood`, `usr2_vcc_pwrgood`, `usr1_vdd_pwrgood` and `usr2_vdd_pwrgood` of the downstream system-control block. Software reaches the block through the same iomem-style bus used by that block.

---
 rtl/pwrgood_monitor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pwrgood_monitor.sv
// Synchronizes and debounces four user-area power-good flags, latches rise/fall events with a maskable irq, iomem register access.
// Optional debounce path enabled by `PWRGOOD_MON_DEBOUNCE_EN; without it clean flags follow the synchronizer directly.
module pwrgood_monitor #(
  parameter logic [31:0] BASE_ADR = 32'h2F00_0100,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] iomem_addr,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready,
  input  logic [3:0]  raw_pwrgood,
  output logic        usr1_vcc_pwrgood,
  output logic        usr2_vcc_pwrgood,
  output logic        usr1_vdd_pwrgood,
  output logic        usr2_vdd_pwrgood,
  output logic        pwrgood_irq
);

  localparam logic [7:0] OFS_STATUS   = 8'h00;
  localparam logic [7:0] OFS_EVENT    = 8'h04;
  localparam logic [7:0] OFS_IRQ_EN   = 8'h08;
  localparam logic [7:0] OFS_DEBOUNCE = 8'h0c;

  logic [3:0]  sync1, sync2, clean, clean_nxt;
  logic [7:0]  event_q, irq_en, event_set, event_clr;
  logic [7:0]  ofs;
  logic        acc, wr;
  logic [31:0] rd_mux, debounce_rd;
  logic        unused_bits;

  assign ofs = iomem_addr[7:0];
  assign acc = iomem_valid && !iomem_ready && (iomem_addr[31:8] == BASE_ADR[31:8]);
  assign wr  = acc && (iomem_wstrb != 4'b0000);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 4'b0;
      sync2 <= 4'b0;
    end else begin
      sync1 <= raw_pwrgood;
      sync2 <= sync1;
    end
  end

`ifdef PWRGOOD_MON_DEBOUNCE_EN
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt [4];

  // >= rather than == so a limit lowered below a running count still releases
  always_comb begin
    clean_nxt = clean;
    for (int i = 0; i < 4; i++) begin
      if (sync2[i] != clean[i] && cnt[i] >= limit) clean_nxt[i] = sync2[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clean <= 4'b0;
      limit <= CNT_W'(16'h00FF);
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      clean <= clean_nxt;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == clean[i] || cnt[i] >= limit) cnt[i] <= '0;
        else                                         cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (wr && ofs == OFS_DEBOUNCE) begin
        for (int b = 0; b < int'(CNT_W); b++) begin
          if (iomem_wstrb[b/8]) limit[b] <= iomem_wdata[b];
        end
      end
    end
  end

  assign debounce_rd = {{(32-CNT_W){1'b0}}, limit};
  assign unused_bits = ^{iomem_wdata[31:16], iomem_wstrb[3:2]};
`else
  assign clean       = sync2;
  assign clean_nxt   = sync1;
  assign debounce_rd = 32'h0;
  assign unused_bits = ^{iomem_wdata[31:8], iomem_wstrb[3:1]};
`endif

  // set has priority over a same-cycle write-1-to-clear
  assign event_set = {clean & ~clean_nxt, clean_nxt & ~clean};
  assign event_clr = (wr && ofs == OFS_EVENT && iomem_wstrb[0]) ? iomem_wdata[7:0] : 8'h00;

  always_comb begin
    rd_mux = 32'h0;
    case (ofs)
      OFS_STATUS:   rd_mux = {24'h0, sync2, clean};
      OFS_EVENT:    rd_mux = {24'h0, event_q};
      OFS_IRQ_EN:   rd_mux = {24'h0, irq_en};
      OFS_DEBOUNCE: rd_mux = debounce_rd;
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      event_q     <= 8'h00;
      irq_en      <= 8'h00;
      pwrgood_irq <= 1'b0;
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
    end else begin
      event_q     <= (event_q & ~event_clr) | event_set;
      pwrgood_irq <= |(event_q & irq_en);
      iomem_ready <= acc;
      if (acc) iomem_rdata <= rd_mux;
      if (wr && ofs == OFS_IRQ_EN && iomem_wstrb[0]) irq_en <= iomem_wdata[7:0];
    end
  end

  assign usr1_vcc_pwrgood = clean[0];
  assign usr2_vcc_pwrgood = clean[1];
  assign usr1_vdd_pwrgood = clean[2];
  assign usr2_vdd_pwrgood = clean[3];

endmodule
